axi_bridge_mo: RTL
==================

// Module: axi_bridge_mo
// PURPOSE
//  Converts two SRAM-like masters into one AXI3 master: instruction fetch (read-only) and data (read/write).
//  Successor bridge with parametrised widths and N outstanding reads per port; sits between the CPU core and the AXI crossbar.
//  Reads are ID-tagged per port. Writes allow one transaction in flight, with AW and W issued concurrently.
//  Data-port ordering and read-after-write safety are enforced by read/write mutual exclusion on that port.
// PARAMETERS
//  ADDR_W   32    address width
//  DATA_W   32    data width; legal values are 32 and 64; strobe width is DATA_W/8
//  RD_OUT   2     max outstanding reads per port, 1..8
//  INST_ID  4'd0  arid/rid used by the inst port
//  DATA_ID  4'd1  arid/rid/awid/wid used by the data port
// PORTS
//  clk                       in   1         clock; every register updates on its rising edge
//  resetn                    in   1         reset, synchronous, active-low
//  inst_sram_req/addr        in   1/ADDR_W  fetch request and address
//  inst_sram_size            in   3         log2 of bytes; drives arsize
//  inst_sram_wr/wstrb/wdata  in   -         ignored; the inst port is read-only
//  inst_sram_addr_ok         out  1         request accepted this cycle
//  inst_sram_data_ok/rdata   out  1/DATA_W  read data returned
//  data_sram_req/wr/addr     in   1/1/ADDR_W  data request; wr=1 means write
//  data_sram_size            in   3         log2 of bytes; drives arsize or awsize
//  data_sram_wstrb/wdata     in   DATA_W/8 / DATA_W  write strobe and data
//  data_sram_addr_ok         out  1         request accepted this cycle
//  data_sram_data_ok/rdata   out  1/DATA_W  read data returned, or write completed
//  arid/araddr/arsize        out  4/ADDR_W/3  read address
//  arvalid / arready         out/in  1      read address handshake
//  rid/rdata/rvalid/rlast    in   4/DATA_W/1/1  read data
//  rready                    out  1         tied to 1
//  awid/awaddr/awsize        out  4/ADDR_W/3  write address
//  awvalid / awready         out/in  1      write address handshake
//  wid/wdata/wstrb           out  4/DATA_W/DATA_W/8  write data
//  wvalid / wready           out/in  1      write data handshake
//  bid/bvalid                in   4/1       write response
//  bready                    out  1         tied to 1
//  rresp/bresp               in   2/2       ignored
//  ar/aw len,burst,lock,cache,prot  out  8,2,2,4,3  constants 0, 2'b01, 0, 0, 0
//  wlast                     out  1         constant 1
// BEHAVIOUR
//  Reset values: arvalid=awvalid=wvalid=0; both outstanding counters=0; write-pending=0; all address/data regs=0.
//  AR slot:
//   - One registered AR slot. An accepted read loads the slot; arvalid rises the next cycle.
//   - araddr/arsize/arid are held stable until arready; the slot is free again the cycle after the handshake.
//   - If arvalid & arready and a new accept occur in the same cycle, the slot reloads and arvalid stays 1.
//  Read accept conditions:
//   - inst addr_ok = slot free (or freeing this cycle) & inst_cnt<RD_OUT & ~(data read req this cycle).
//   - Data read addr_ok = slot free & dcnt<RD_OUT & ~wr_pend.
//   - Data has priority when both ports request a read in the same cycle; inst addr_ok=0 that cycle.
//  Write accept condition:
//   - Data write addr_ok = ~wr_pend & dcnt==0 & ~(AR slot holding a data read).
//  Write issue:
//   - An accepted write latches addr/size/wstrb/wdata and sets wr_pend; awvalid and wvalid rise the next cycle.
//   - awvalid and wvalid each drop independently on their own ready, in either order or the same cycle.
//   - wr_pend clears on bvalid; data_sram_data_ok=1 in that same cycle.
//  Counters:
//   - Increment on addr_ok&req for a read; decrement on rvalid&rlast with matching rid.
//   - Increment and decrement in the same cycle leave the count unchanged.
//   - At count==RD_OUT, addr_ok=0 for that port.
//  Read return:
//   - Combinational: {inst|data}_sram_data_ok = rvalid & rid==ID; rdata is driven straight from AXI rdata.
//   - A read data_ok and a write data_ok never coincide, guaranteed by the mutual exclusion above.
//  Reset mid-operation clears all state; in-flight AXI transactions are abandoned, and the slave must be reset as well.
// TESTING
//  1. Inst reads at A0,A4,A8 with rvalid delayed 5 cycles: 3rd addr_ok=0 (RD_OUT=2) until first rid=0 return; data returns in order.
//  2. Inst and data reads requested in the same cycle: araddr carries the data addr with arid=1 first, then the inst addr with arid=0; both data_ok fire.
//  3. Write 0x1000, wstrb=4'b0011: wready returned 3 cycles before awready -> both handshakes complete; data_ok on bvalid; wdata/wstrb exact.
//  4. Data read requested while a write is pending: addr_ok=0 until the cycle after bvalid; the read then issues with arid=1.
//  5. arready held low for 10 cycles: araddr/arid/arsize stay constant and no extra addr_ok occurs.
//  6. resetn=0 with 2 reads outstanding: all valids=0 next cycle; counters=0; first request after reset is accepted.

Source files
------------

// File: rtl/axi_bridge_mo.sv
// rtl/axi_bridge_mo.sv - two SRAM-like masters (fetch, data) onto one AXI3 master port
// Shared single AR slot, per-port outstanding-read counters, one write in flight.
module axi_bridge_mo #(
    parameter int         ADDR_W  = 32,
    parameter int         DATA_W  = 32,
    parameter int         RD_OUT  = 2,
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic                clk,
    input  logic                resetn,

    input  logic                inst_sram_req,
    input  logic                inst_sram_wr,
    input  logic [2:0]          inst_sram_size,
    input  logic [DATA_W/8-1:0] inst_sram_wstrb,
    input  logic [ADDR_W-1:0]   inst_sram_addr,
    input  logic [DATA_W-1:0]   inst_sram_wdata,
    output logic                inst_sram_addr_ok,
    output logic                inst_sram_data_ok,
    output logic [DATA_W-1:0]   inst_sram_rdata,

    input  logic                data_sram_req,
    input  logic                data_sram_wr,
    input  logic [2:0]          data_sram_size,
    input  logic [DATA_W/8-1:0] data_sram_wstrb,
    input  logic [ADDR_W-1:0]   data_sram_addr,
    input  logic [DATA_W-1:0]   data_sram_wdata,
    output logic                data_sram_addr_ok,
    output logic                data_sram_data_ok,
    output logic [DATA_W-1:0]   data_sram_rdata,

    output logic [3:0]          arid,
    output logic [ADDR_W-1:0]   araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic [1:0]          arlock,
    output logic [3:0]          arcache,
    output logic [2:0]          arprot,
    output logic                arvalid,
    input  logic                arready,

    input  logic [3:0]          rid,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,

    output logic [3:0]          awid,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic [1:0]          awlock,
    output logic [3:0]          awcache,
    output logic [2:0]          awprot,
    output logic                awvalid,
    input  logic                awready,

    output logic [3:0]          wid,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,

    input  logic [3:0]          bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    localparam int               CNT_W   = $clog2(RD_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RD_OUT);

    logic [CNT_W-1:0] inst_cnt;
    logic [CNT_W-1:0] data_cnt;
    logic             wr_pend;

    logic slot_avail;
    logic data_rd_req;
    logic inst_rd_ok;
    logic data_rd_ok;
    logic data_wr_ok;
    logic inst_acc;
    logic data_rd_acc;
    logic data_wr_acc;
    logic inst_ret;
    logic data_ret;

    // The slot counts as free in the cycle its current address is being taken.
    assign slot_avail  = ~arvalid | arready;
    assign data_rd_req = data_sram_req & ~data_sram_wr;

    assign inst_rd_ok = slot_avail & (inst_cnt != CNT_MAX) & ~data_rd_req;
    assign data_rd_ok = slot_avail & (data_cnt != CNT_MAX) & ~wr_pend;
    // A write waits for every data-port read to finish so reads and writes never overlap.
    assign data_wr_ok = ~wr_pend & (data_cnt == '0) & ~(arvalid & (arid == DATA_ID));

    assign inst_acc    = inst_sram_req & inst_rd_ok;
    assign data_rd_acc = data_rd_req & data_rd_ok;
    assign data_wr_acc = data_sram_req & data_sram_wr & data_wr_ok;

    assign inst_sram_addr_ok = inst_acc;
    assign data_sram_addr_ok = data_rd_acc | data_wr_acc;

    assign inst_ret = rvalid & (rid == INST_ID);
    assign data_ret = rvalid & (rid == DATA_ID);

    assign inst_sram_data_ok = inst_ret;
    assign data_sram_data_ok = data_ret | bvalid;
    assign inst_sram_rdata   = rdata;
    assign data_sram_rdata   = rdata;

    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign awid    = DATA_ID;
    assign awlen   = 8'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wid     = DATA_ID;
    assign wlast   = 1'b1;
    assign rready  = 1'b1;
    assign bready  = 1'b1;

    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rresp, bresp, bid};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            arvalid  <= 1'b0;
            arid     <= '0;
            araddr   <= '0;
            arsize   <= '0;
            awvalid  <= 1'b0;
            wvalid   <= 1'b0;
            awaddr   <= '0;
            awsize   <= '0;
            wdata    <= '0;
            wstrb    <= '0;
            wr_pend  <= 1'b0;
            inst_cnt <= '0;
            data_cnt <= '0;
        end else begin
            if (data_rd_acc) begin
                arvalid <= 1'b1;
                arid    <= DATA_ID;
                araddr  <= data_sram_addr;
                arsize  <= data_sram_size;
            end else if (inst_acc) begin
                arvalid <= 1'b1;
                arid    <= INST_ID;
                araddr  <= inst_sram_addr;
                arsize  <= inst_sram_size;
            end else if (arready) begin
                arvalid <= 1'b0;
            end

            inst_cnt <= inst_cnt + CNT_W'(inst_acc) - CNT_W'(inst_ret & rlast);
            data_cnt <= data_cnt + CNT_W'(data_rd_acc) - CNT_W'(data_ret & rlast);

            if (data_wr_acc) begin
                wr_pend <= 1'b1;
                awvalid <= 1'b1;
                wvalid  <= 1'b1;
                awaddr  <= data_sram_addr;
                awsize  <= data_sram_size;
                wdata   <= data_sram_wdata;
                wstrb   <= data_sram_wstrb;
            end else begin
                if (awready) awvalid <= 1'b0;
                if (wready)  wvalid  <= 1'b0;
                if (bvalid)  wr_pend <= 1'b0;
            end
        end
    end

endmodule
